// File: rtl/seven_seg_scan.sv
// Multiplexed hex seven-segment scanner with a shadow register that commits on frame wrap.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LZB_EN.
module seven_seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]   shadow_mask;
    logic [4*NUM_DIGITS-1:0] disp_value;
    logic [NUM_DIGITS-1:0]   disp_mask;
    logic                    dwell_end;
    logic                    frame_wrap;
    logic [3:0]              nibble;
    logic                    blank;
    logic [6:0]              seg_next;
    logic [NUM_DIGITS-1:0]   an_next;
`ifdef SEVEN_SEG_LZB_EN
    logic                    nonzero_above;
`endif

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0011000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            4'hF: decode = 7'b0001110;
        endcase
    endfunction

    assign dwell_end  = (cnt == CNT_LAST);
    assign frame_wrap = dwell_end && (idx == IDX_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (dwell_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow always tracks the last load, so it equals the display whenever nothing is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_value <= '0;
            shadow_mask  <= '0;
            disp_value   <= '0;
            disp_mask    <= '0;
            pending      <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            if (load) begin
                shadow_value <= value;
                shadow_mask  <= blank_mask;
            end
            if (frame_wrap) begin
                disp_value <= load ? value : shadow_value;
                disp_mask  <= load ? blank_mask : shadow_mask;
                pending    <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
            frame_done <= frame_wrap;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        nibble = disp_value[idx*4 +: 4];
        blank  = disp_mask[idx];
`ifdef SEVEN_SEG_LZB_EN
        nonzero_above = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx) && disp_value[4*i +: 4] != 4'h0) nonzero_above = 1'b1;
        end
        if (idx != '0 && !nonzero_above) blank = 1'b1;
`endif
        seg_next = blank ? 7'b1111111 : decode(nibble);
        an_next  = '1;
        if (!blank) an_next[idx] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= 7'b1111111;
            an  <= '1;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomised scoreboard bench for seven_seg_scan (NUM_DIGITS=4, REFRESH_DIV=4); follows SEVEN_SEG_LZB_EN if defined.
module tb_seven_seg_scan;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  blank_mask = '0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        pending;
    logic        frame_done;

    always #5 clk = ~clk;

    seven_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .blank_mask(blank_mask),
        .seg(seg), .an(an), .pending(pending), .frame_done(frame_done)
    );

    typedef struct {
        int          edge_no;
        logic [15:0] v;
        logic [3:0]  m;
    } load_t;

    typedef struct {
        int         k;
        logic [6:0] seg;
        logic [3:0] an;
        logic       pend;
        logic       fd;
    } exp_t;

    load_t loads[$];
    exp_t  sb[$];
    int    k;
    int    vectors = 0;
    int    miscompares = 0;

    logic [6:0] font [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs just after clock edge kk (edge 1 = first edge after reset release).
    // A load at edge j reaches the display at the first frame boundary edge c >= j (multiples of FRAME).
    function automatic exp_t model(input int kk);
        exp_t        e;
        int          digit;
        int          c;
        logic [15:0] dv;
        logic [3:0]  dm;
        bit          blank;
        digit  = ((kk - 1) % FRAME) / RD;
        dv     = '0;
        dm     = '0;
        e.k    = kk;
        e.pend = 1'b0;
        foreach (loads[i]) begin
            c = ((loads[i].edge_no + FRAME - 1) / FRAME) * FRAME;
            if (c <= kk - 1) begin
                dv = loads[i].v;
                dm = loads[i].m;
            end
            if (loads[i].edge_no <= kk && c > kk) e.pend = 1'b1;
        end
        blank = dm[digit];
`ifdef SEVEN_SEG_LZB_EN
        if (digit != 0 && (dv >> (4 * digit)) == 16'h0) blank = 1'b1;
`endif
        e.seg = blank ? 7'h7F : font[dv[4*digit +: 4]];
        e.an  = blank ? 4'hF : ~(4'b0001 << digit);
        e.fd  = (kk % FRAME == 0);
        return e;
    endfunction

    task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] m);
        load       = ld;
        value      = v;
        blank_mask = m;
        if (ld) loads.push_back(load_t'{k + 1, v, m});
        @(posedge clk);
        k++;
        sb.push_back(model(k));
        #1;
        load = 1'b0;
    endtask

    task automatic idle_to(input int target);
        while (k + 1 < target) step(1'b0, 16'h0, 4'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"}, seg, 7'h7F);
        check({tag, "_an"}, an, 4'hF);
        check({tag, "_pending"}, pending, 1'b0);
        check({tag, "_frame_done"}, frame_done, 1'b0);
    endtask

    task automatic release_reset();
        k = 0;
        loads.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("post_rst_cycle1");
    endtask

    task automatic random_run(input int n);
        bit          ld;
        logic [15:0] v;
        logic [3:0]  m;
        for (int i = 0; i < n; i++) begin
            ld = ($urandom_range(0, 9) == 0);
            if ((k + 1) % FRAME == 0 && $urandom_range(0, 1) == 1) ld = 1'b1;
            v = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            m = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            step(ld, v, m);
        end
    endtask

    // Monitor: one output vector per clock, sampled on the falling edge.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && sb.size() > 0) begin
            mon_e = sb.pop_front();
            check($sformatf("seg@%0d", mon_e.k), seg, mon_e.seg);
            check($sformatf("an@%0d", mon_e.k), an, mon_e.an);
            check($sformatf("pending@%0d", mon_e.k), pending, mon_e.pend);
            check($sformatf("frame_done@%0d", mon_e.k), frame_done, mon_e.fd);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        k = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        release_reset();

        // Mid-frame load, then two loads in one frame (only the last survives),
        // then loads coincident with frame wraps.
        idle_to(6);  step(1'b1, 16'h12AF, 4'b0000);
        idle_to(20); step(1'b1, 16'h1234, 4'b0000);
        idle_to(25); step(1'b1, 16'h5678, 4'b0000);
        idle_to(48); step(1'b1, 16'h0005, 4'b0100);
        idle_to(64); step(1'b1, 16'h0000, 4'b0000);
        idle_to(81);

        random_run(800);

        // Reset mid-dwell while a load is pending.
        while ((k + 1) % FRAME != 3) step(1'b0, 16'h0, 4'h0);
        step(1'b1, 16'hBEEF, 4'h0);
        step(1'b0, 16'h0, 4'h0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("in_reset2");
        release_reset();
        idle_to(40);

        random_run(300);

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, meaning the number of multiplexed hex digits; legal range is 1 to 8.
REQ-002 The block SHALL have parameter REFRESH_DIV, default 50000, meaning clk cycles per digit dwell; the minimum is 2.
REQ-003 The block SHALL have port clk, input, width 1: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, width 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port load, input, width 1: capture value and blank_mask this cycle.
REQ-006 The block SHALL have port value, input, width 4*NUM_DIGITS: one hex nibble per digit, digit 0 in [3:0].
REQ-007 The block SHALL have port blank_mask, input, width NUM_DIGITS: 1 blanks that digit.
REQ-008 The block SHALL have port seg, output, width 7: active-low segments, order gfedcba.
REQ-009 The block SHALL have port an, output, width NUM_DIGITS: active-low digit enables.
REQ-010 The block SHALL have port pending, output, width 1: a captured value is waiting for the frame boundary.
REQ-011 The block SHALL have port frame_done, output, width 1: one-cycle pulse on each frame wrap.

Function
REQ-012 A dwell counter SHALL count 0..REFRESH_DIV-1 and wrap; at terminal count the digit index SHALL advance by 1, wrapping NUM_DIGITS-1 to 0 (the frame wrap).
REQ-013 seg and an SHALL be registered and reflect the digit index with exactly one cycle of latency; exactly one an bit SHALL be low when the current digit is not blanked.
REQ-014 Nibble decode (seg, gfedcba, active-low) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-015 For a blanked digit, seg SHALL be 1111111 and all an bits SHALL be 1 for the whole dwell.
REQ-016 On load=1, value and blank_mask SHALL be captured into a shadow register and pending SHALL be set the next cycle.
REQ-017 The shadow register SHALL be copied to the display register on the frame wrap edge, and pending SHALL be cleared on that same edge; the display SHALL never change mid-frame.
REQ-018 A load on a non-wrap cycle while pending=1 SHALL overwrite the shadow register, and only the last load SHALL be displayed.
REQ-019 A load coincident with the frame wrap SHALL commit directly to the display register at that edge, and pending SHALL remain 0.
REQ-020 frame_done SHALL be a registered 1-cycle pulse in the cycle after each frame wrap edge.
REQ-021 With NUM_DIGITS=1, every dwell terminal count SHALL be a frame wrap.

Reset
REQ-022 While rst=1 the block SHALL force seg=1111111, an all 1, pending=0, frame_done=0, dwell counter=0, digit index=0, and display and shadow registers=0 (blank_mask=0), asynchronously.
REQ-023 In the first cycle after rst deassertion, seg and an SHALL remain at their reset values; on the next edge they SHALL show digit 0 as 1000000 with an[0]=0.
REQ-024 A reset asserted mid-frame or with pending=1 SHALL discard the pending value.

Configuration
REQ-025 When macro SEVEN_SEG_LZB_EN is defined, zero nibbles above the most-significant nonzero nibble SHALL be blanked per REQ-015, and digit 0 SHALL never be suppressed; without the macro, all unmasked digits SHALL display normally; blank_mask SHALL apply in both builds.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-026 Hold rst for 3 cycles, then release it -> seg=1111111 and an=1111 during reset and for 1 cycle after; then an=1110, seg=1000000.
REQ-027 Pulse load with value=16'h12AF mid-frame -> pending=1 until the wrap; the next frame shows an 1110/1101/1011/0111 with seg 0001110/0001000/0100100/1111001, each for 4 cycles; frame_done pulses once per 16 cycles.
REQ-028 Load 16'h1234 then 16'h5678 in the same frame -> only 5678 is ever displayed; the first frame is unchanged.
REQ-029 Load coincident with the wrap, blank_mask=4'b0100 -> the commit is immediate, pending stays 0, and the digit 2 dwell shows an=1111, seg=1111111.
REQ-030 With SEVEN_SEG_LZB_EN, load 16'h0005 -> digits 3..1 are blank and digit 0 shows 0010010; load 16'h0000 -> digit 0 shows 1000000. Without the macro, 16'h0005 shows 0,0,0,5.
REQ-031 Assert rst mid-dwell with pending=1 -> all outputs take their reset values immediately, pending=0, and the display restarts at digit 0 with value 0.
